hex_dff_load_sequencer: RTL and testbench

//  Shares one 6-bit hex D-register bank (LS174-class, no clock enable) between NREQ requesters.

---
 rtl/hex_dff_load_sequencer_pkg.sv | 14 +
 rtl/hex_dff_load_sequencer_rr_arbiter.sv | 32 +++
 rtl/hex_dff_load_sequencer.sv | 151 +++++++++++++++
 tb/tb_hex_dff_load_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_dff_load_sequencer_pkg.sv
// Shared encodings for the hex D-register load sequencer.
package hex_dff_load_sequencer_pkg;

  localparam int unsigned DefaultSettle = 2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StStrobe = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
  localparam logic [2:0] StAck    = 3'd4;
  localparam logic [2:0] StClear  = 3'd5;
  localparam logic [2:0] StClrAck = 3'd6;

endpackage

// File: rtl/hex_dff_load_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr_i wins.
module hex_dff_load_sequencer_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  logic [PtrW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PtrW'((32'(ptr_i) + 32'(i)) % NREQ);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/hex_dff_load_sequencer.sv
// Arbitrates NREQ requesters onto one clock-enable-less hex D bank: latches data, strobes the
// bank clock, waits for the outputs to settle, then acks. Also sequences bank clears.
module hex_dff_load_sequencer
  import hex_dff_load_sequencer_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned SETTLE = DefaultSettle
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  clr_req,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  clr_ack,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  reg_clk,
  output logic                  reg_clr,
  output logic                  busy
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NREQ - 1);

  logic [2:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             clr_ack_q, clr_ack_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             reg_clk_q, reg_clk_d;
  logic             reg_clr_q, reg_clr_d;
  logic             busy_q, busy_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [NREQ-1:0]  win_gnt;
  logic [PtrW-1:0]  win_idx;
  logic             win_valid;
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = data[g*WIDTH +: WIDTH];
  end

  hex_dff_load_sequencer_rr_arbiter #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    clr_ack_d = 1'b0;
    reg_d_d   = reg_d_q;
    reg_clk_d = 1'b0;
    reg_clr_d = 1'b1;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Clears take priority over pending loads.
        if (clr_req) begin
          state_d   = StClear;
          reg_clr_d = 1'b0;
        end else if (win_valid) begin
          state_d = StSetup;
          gnt_d   = win_gnt;
          reg_d_d = data_arr[win_idx];
          ptr_d   = (win_idx == PtrLast) ? '0 : win_idx + 1'b1;
        end
      end
      StSetup: begin
        state_d   = StStrobe;
        reg_clk_d = 1'b1;
      end
      StStrobe: begin
        state_d = StHold;
        cnt_d   = '0;
      end
      StHold: begin
        if (cnt_q == CntLast) begin
          state_d = StAck;
          ack_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      StClear: begin
        state_d   = StClrAck;
        clr_ack_d = 1'b1;
      end
      StClrAck: state_d = StIdle;
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // The bank is held clear for as long as the controller itself is in reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      ack_q     <= '0;
      clr_ack_q <= 1'b0;
      reg_d_q   <= '0;
      reg_clk_q <= 1'b0;
      reg_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      clr_ack_q <= clr_ack_d;
      reg_d_q   <= reg_d_d;
      reg_clk_q <= reg_clk_d;
      reg_clr_q <= reg_clr_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign clr_ack = clr_ack_q;
  assign reg_d   = reg_d_q;
  assign reg_clk = reg_clk_q;
  assign reg_clr = reg_clr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_hex_dff_load_sequencer.sv
// Directed bench: drives the sequencer into a behavioural LS174 bank and checks bank q.
module tb_hex_dff_load_sequencer;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned WIDTH  = 6;
  localparam int unsigned SETTLE = 2;

  logic                  clk;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic                  clr_req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  clr_ack;
  logic [WIDTH-1:0]      reg_d;
  logic                  reg_clk;
  logic                  reg_clr;
  logic                  busy;

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] prev_d;
  logic             prev_clk = 1'b0;
  logic             viol = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  hex_dff_load_sequencer #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .data    (data),
    .clr_req (clr_req),
    .gnt     (gnt),
    .ack     (ack),
    .clr_ack (clr_ack),
    .reg_d   (reg_d),
    .reg_clk (reg_clk),
    .reg_clr (reg_clr),
    .busy    (busy)
  );

  // LS174-style bank: rising-edge D flops with asynchronous active-low clear.
  always @(posedge reg_clk or negedge reg_clr) begin
    if (!reg_clr) bank_q <= '0;
    else          bank_q <= reg_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank clock must never pulse while cleared, and reg_d must be stable around a strobe.
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      if (reg_clk === 1'b1 && reg_clr !== 1'b1) viol = 1'b1;
      if ((reg_clk === 1'b1 || prev_clk === 1'b1) && reg_d !== prev_d) viol = 1'b1;
    end
    prev_clk = reg_clk;
    prev_d   = reg_d;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr     = 1'b0;
    req     = '0;
    clr_req = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
  endtask

  // Entered and left in IDLE, one time unit after a rising edge.
  task automatic do_clear(input string name);
    clr_req = 1'b1;
    tick();
    check({name, " clear reg_clr"}, 32'(reg_clr), 32'h0);
    check({name, " clear bank"}, 32'(bank_q), 32'h0);
    tick();
    check({name, " clr_ack"}, 32'(clr_ack), 32'h1);
    check({name, " clrack reg_clr"}, 32'(reg_clr), 32'h1);
    clr_req = 1'b0;
    tick();
    check({name, " clr_ack drop"}, 32'(clr_ack), 32'h0);
  endtask

  // mode 0: plain load, 1: raise clr_req in HOLD, 2: corrupt winner data in STROBE
  task automatic do_load(input string name, input logic [NREQ-1:0] req_v, input int w,
                         input logic [WIDTH-1:0] q, input bit hold, input int mode);
    logic [NREQ-1:0] oh;
    oh  = NREQ'(1) << w;
    req = req_v;
    tick();
    check({name, " gnt"}, 32'(gnt), 32'(oh));
    tick();
    check({name, " reg_clk"}, 32'(reg_clk), 32'h1);
    if (mode == 2) data[w*WIDTH +: WIDTH] = 6'h3F;
    for (int i = 0; i < int'(SETTLE); i++) begin
      tick();
      if (mode == 1 && i == 0) clr_req = 1'b1;
    end
    tick();
    check({name, " ack"}, 32'(ack), 32'(oh));
    check({name, " bank q"}, 32'(bank_q), 32'(q));
    check({name, " reg_d"}, 32'(reg_d), 32'(q));
    if (!hold) req = '0;
    tick();
    check({name, " ack drop"}, 32'(ack | gnt), 32'h0);
  endtask

  typedef struct {
    bit                    rst;
    bit                    clr_first;
    bit                    hold;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    int                    w;
    logic [WIDTH-1:0]      q;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1, 0, 0, 4'b0001, {6'h00, 6'h00, 6'h00, 6'h2A}, 0, 6'h2A};
    vecs[1] = '{1, 0, 1, 4'b1111, {6'h04, 6'h33, 6'h22, 6'h11}, 0, 6'h11};
    vecs[2] = '{0, 0, 1, 4'b1111, {6'h04, 6'h33, 6'h22, 6'h11}, 1, 6'h22};
    vecs[3] = '{0, 0, 1, 4'b1111, {6'h04, 6'h33, 6'h22, 6'h11}, 2, 6'h33};
    vecs[4] = '{0, 0, 1, 4'b1111, {6'h04, 6'h33, 6'h22, 6'h11}, 3, 6'h04};
    vecs[5] = '{0, 0, 0, 4'b1111, {6'h04, 6'h33, 6'h22, 6'h11}, 0, 6'h11};
    vecs[6] = '{0, 1, 0, 4'b0010, {6'h00, 6'h00, 6'h2C, 6'h00}, 1, 6'h2C};
    vecs[7] = '{0, 0, 0, 4'b1001, {6'h3E, 6'h00, 6'h00, 6'h07}, 3, 6'h3E};
    vecs[8] = '{0, 0, 0, 4'b1001, {6'h3E, 6'h00, 6'h00, 6'h07}, 0, 6'h07};

    clr     = 1'b0;
    req     = '0;
    data    = '0;
    clr_req = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'h0);
    check("reset gnt", 32'(gnt | ack), 32'h0);
    check("reset reg_clr", 32'(reg_clr), 32'h0);
    check("reset reg_clk", 32'(reg_clk), 32'h0);
    check("reset reg_d", 32'(reg_d), 32'h0);
    check("reset bank", 32'(bank_q), 32'h0);
    clr = 1'b1;
    tick();
    check("post-reset reg_clr", 32'(reg_clr), 32'h1);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rst) do_reset();
      data = vecs[v].data;
      if (vecs[v].clr_first) begin
        req = vecs[v].req;
        do_clear($sformatf("vec%0d", v));
      end
      do_load($sformatf("vec%0d", v), vecs[v].req, vecs[v].w, vecs[v].q, vecs[v].hold, 0);
    end

    // clr_req during HOLD: load finishes first, then the bank clears.
    data = {6'h00, 6'h15, 6'h00, 6'h00};
    do_load("midclr", 4'b0100, 2, 6'h15, 0, 1);
    check("midclr no early clr_ack", 32'(clr_ack), 32'h0);
    do_clear("midclr");

    // Data change after SETUP must not reach the bank.
    data = {6'h00, 6'h00, 6'h00, 6'h01};
    do_load("latch", 4'b0001, 0, 6'h01, 0, 2);

    // Reset during HOLD aborts silently and clears the bank and pointer.
    data = {6'h00, 6'h19, 6'h00, 6'h00};
    req  = 4'b0100;
    tick();
    tick();
    tick();
    clr = 1'b0;
    tick();
    check("rst busy", 32'(busy), 32'h0);
    check("rst gnt/ack", 32'(gnt | ack), 32'h0);
    check("rst reg_clr", 32'(reg_clr), 32'h0);
    check("rst bank", 32'(bank_q), 32'h0);
    req = '0;
    tick();
    check("rst no ack", 32'(ack), 32'h0);
    clr = 1'b1;
    tick();
    check("rst release reg_clr", 32'(reg_clr), 32'h1);
    data = {6'h24, 6'h23, 6'h22, 6'h21};
    do_load("rst ptr", 4'b1111, 0, 6'h21, 0, 0);

    check("strobe protocol", 32'(viol), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
